// File: rtl/prewish5k_pkg.sv
// rtl/prewish5k_pkg.sv - shared types and widths for the blinker and its controller
// The controller derives NEWMASK_CLK_BITS from the blinker prescaler width kept here.
package prewish5k_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MASK_W = 8;
  localparam int IDX_W  = 3;

  localparam int BLINKY_MASK_CLK_BITS_DEF = 19;
  localparam int NEWMASK_CLK_BITS_DEF     = BLINKY_MASK_CLK_BITS_DEF + 7;

  localparam logic [IDX_W-1:0] IDX_MSB = 3'd7;
  localparam logic [IDX_W-1:0] IDX_LSB = 3'd0;

endpackage

// File: rtl/prewish5k_prescaler.sv
// rtl/prewish5k_prescaler.sv - free-running counter with enable, synchronous clear and tick
// o_tick flags the all-ones count; the counter then wraps to zero on its own.
module prewish5k_prescaler #(
  parameter int WIDTH = 19
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = i_en & (&r_count);

endmodule

// File: rtl/prewish5k_mask_blinker.sv
// rtl/prewish5k_mask_blinker.sv - strobe-loaded 8-bit LED blink mask player, MSB first
// PREWISH5K_BLINKY_SYNC_LOAD_EN defers loads made while running to the next frame boundary.
module prewish5k_mask_blinker
  import prewish5k_pkg::*;
#(
  parameter int BLINKY_MASK_CLK_BITS = BLINKY_MASK_CLK_BITS_DEF
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              o_led,
  output logic              o_pending,
  output logic              o_frame
);

  state_e             r_state;
  logic               r_stb_d;
  logic               r_ack;
  logic               r_led;
  logic               r_frame;
  logic [IDX_W-1:0]   r_idx;
  logic [MASK_W-1:0]  r_active;

  logic w_accept;
  logic w_run;
  logic w_tick;
  logic w_boundary;
  logic w_clr;

  assign w_accept   = STB_I & ~r_stb_d;
  assign w_run      = (r_state == RUN);
  assign w_boundary = w_tick & (r_idx == IDX_LSB);

`ifdef PREWISH5K_BLINKY_SYNC_LOAD_EN
  assign w_clr = w_accept & ~w_run;
`else
  assign w_clr = w_accept;
`endif

  prewish5k_prescaler #(
    .WIDTH (BLINKY_MASK_CLK_BITS)
  ) u_prescaler (
    .i_clk  (CLK_I),
    .i_rst  (RST_I),
    .i_en   (w_run),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

`ifdef PREWISH5K_BLINKY_SYNC_LOAD_EN
  logic              r_pending;
  logic [MASK_W-1:0] r_pend_mask;

  // A strobe landing on the boundary tick bypasses the pending register entirely.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_pending   <= 1'b0;
      r_pend_mask <= '0;
    end else if (w_run && w_accept && !w_boundary) begin
      r_pending   <= 1'b1;
      r_pend_mask <= DAT_I;
    end else if (w_boundary) begin
      r_pending   <= 1'b0;
    end
  end

  assign o_pending = r_pending;
`else
  assign o_pending = 1'b0;
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state  <= IDLE;
      r_stb_d  <= 1'b0;
      r_ack    <= 1'b0;
      r_led    <= 1'b0;
      r_frame  <= 1'b0;
      r_idx    <= IDX_MSB;
      r_active <= '0;
    end else begin
      r_stb_d <= STB_I;
      r_ack   <= w_accept;
      r_frame <= w_boundary;
      r_led   <= w_run & r_active[r_idx];
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_active <= DAT_I;
            r_idx    <= IDX_MSB;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (w_boundary) begin
            r_idx <= IDX_MSB;
          end else if (w_tick) begin
            r_idx <= r_idx - 1'b1;
          end
`ifdef PREWISH5K_BLINKY_SYNC_LOAD_EN
          if (w_boundary) begin
            if (w_accept) begin
              r_active <= DAT_I;
            end else if (r_pending) begin
              r_active <= r_pend_mask;
            end
          end
`else
          if (w_accept) begin
            r_active <= DAT_I;
            r_idx    <= IDX_MSB;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ACK_O   = r_ack;
  assign o_led   = r_led;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_prewish5k_mask_blinker.sv
// tb/tb_prewish5k_mask_blinker.sv - directed vector bench for the mask blinker, prescaler width 3
module tb_prewish5k_mask_blinker;

  localparam int BITS = 3;
  localparam int STEP = 8;

`ifdef PREWISH5K_BLINKY_SYNC_LOAD_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       stb;
  logic [7:0] dat;
  logic       ack;
  logic       led;
  logic       pending;
  logic       frame;

  int n_vec = 0;
  int n_err = 0;

  prewish5k_mask_blinker #(
    .BLINKY_MASK_CLK_BITS (BITS)
  ) dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .STB_I     (stb),
    .DAT_I     (dat),
    .ACK_O     (ack),
    .o_led     (led),
    .o_pending (pending),
    .o_frame   (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    int         hold;
    logic [7:0] exp_seq;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int rel, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s rel=%0d got=%b want=%b", name, rel, act, exp);
    end
  endtask

  function automatic logic exp_led(input logic [7:0] m, input int base, input int r);
    logic [7:0] mm;
    int         b;
    mm = m;
    if (r < base) return 1'b0;
    b = 7 - (((r - base) / STEP) % 8);
    return mm[b];
  endfunction

  // scn 0: plain load; 1: two loads mid-frame; 2: strobe on boundary tick; 3: reset with pending
  task automatic drive(input int scn, input int rel, input logic [7:0] m0, input int hold0);
    rst = 1'b0;
    stb = 1'b0;
    dat = m0;
    case (scn)
      0: stb = (rel < hold0);
      1: begin
        if (rel == 0)  stb = 1'b1;
        if (rel == 30) begin stb = 1'b1; dat = 8'h33; end
        if (rel == 40) begin stb = 1'b1; dat = 8'h0F; end
      end
      2: begin
        if (rel == 0)  stb = 1'b1;
        if (rel == 64) begin stb = 1'b1; dat = 8'hFF; end
      end
      default: begin
        if (rel == 0)  stb = 1'b1;
        if (rel == 30) begin stb = 1'b1; dat = 8'h33; end
        if (rel == 40) rst = 1'b1;
      end
    endcase
  endtask

  task automatic check_rel(input int scn, input int r, input logic [7:0] m0, input logic [7:0] seq);
    logic e_ack, e_led, e_pend, e_frame;
    e_ack = (r == 1);
    e_frame = 1'b0;
    e_pend = 1'b0;
    case (scn)
      0: begin
        e_led   = exp_led(seq, 2, r);
        e_frame = (r == 65) || (r == 129);
      end
      1: begin
        e_ack = (r == 1) || (r == 31) || (r == 41);
        if (SYNC) begin
          e_pend  = (r >= 31) && (r <= 64);
          e_frame = (r == 65) || (r == 129);
          e_led   = (r < 66) ? exp_led(8'hA0, 2, r) : exp_led(8'h0F, 2, r);
        end else begin
          e_frame = (r == 105);
          if (r < 32)      e_led = exp_led(8'hA0, 2, r);
          else if (r < 42) e_led = exp_led(8'h33, 32, r);
          else             e_led = exp_led(8'h0F, 42, r);
        end
      end
      2: begin
        e_ack   = (r == 1) || (r == 65);
        e_frame = (r == 65) || (r == 129);
        e_led   = (r < 66) ? exp_led(8'hA0, 2, r) : exp_led(8'hFF, 2, r);
      end
      default: begin
        e_ack = (r == 1) || (r == 31);
        if (SYNC) e_pend = (r >= 31) && (r <= 40);
        if (r >= 41)                e_led = 1'b0;
        else if (!SYNC && r >= 32)  e_led = exp_led(8'h33, 32, r);
        else                        e_led = exp_led(8'hA0, 2, r);
      end
    endcase
    chk($sformatf("ack/s%0d/m%h", scn, m0), r, ack, e_ack);
    chk($sformatf("led/s%0d/m%h", scn, m0), r, led, e_led);
    chk($sformatf("pending/s%0d/m%h", scn, m0), r, pending, e_pend);
    chk($sformatf("frame/s%0d/m%h", scn, m0), r, frame, e_frame);
  endtask

  task automatic run_scn(input int scn, input logic [7:0] m0, input int hold0,
                         input logic [7:0] seq, input int last_rel);
    for (int rel = 0; rel < last_rel; rel++) begin
      drive(scn, rel, m0, hold0);
      step();
      check_rel(scn, rel + 1, m0, seq);
    end
    rst = 1'b0;
    stb = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = 1'b0;
    dat = 8'h00;
    step();
    step();
    chk("reset_ack", 0, ack, 1'b0);
    chk("reset_led", 0, led, 1'b0);
    chk("reset_pending", 0, pending, 1'b0);
    chk("reset_frame", 0, frame, 1'b0);
    rst = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{dat: 8'hA0, hold: 5, exp_seq: 8'b1010_0000};
    vecs[1] = '{dat: 8'h00, hold: 1, exp_seq: 8'b0000_0000};
    vecs[2] = '{dat: 8'hFF, hold: 3, exp_seq: 8'b1111_1111};
    vecs[3] = '{dat: 8'h5A, hold: 1, exp_seq: 8'b0101_1010};
    vecs[4] = '{dat: 8'h81, hold: 2, exp_seq: 8'b1000_0001};

    rst = 1'b1;
    stb = 1'b0;
    dat = 8'h00;

    do_reset();
    for (int c = 0; c < 200; c++) begin
      step();
      chk("idle_led", c, led, 1'b0);
      chk("idle_ack", c, ack, 1'b0);
      chk("idle_frame", c, frame, 1'b0);
    end

    for (int v = 0; v < 5; v++) begin
      do_reset();
      step();
      run_scn(0, vecs[v].dat, vecs[v].hold, vecs[v].exp_seq, 140);
    end

    do_reset();
    run_scn(1, 8'hA0, 1, 8'hA0, 140);

    do_reset();
    run_scn(2, 8'hA0, 1, 8'hA0, 140);

    do_reset();
    run_scn(3, 8'hA0, 1, 8'hA0, 60);
    run_scn(0, vecs[3].dat, 1, vecs[3].exp_seq, 140);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
